// File: rtl/tc_program_window_pkg.sv
// rtl/tc_program_window_pkg.sv - shared types, default parameters and index helper for tc_program_window
package tc_program_pkg;

   localparam int DEF_WORD_WIDTH = 16;
   localparam int DEF_DEPTH      = 256;
   localparam int DEF_NUM_OUT    = 4;
   localparam int DEF_ADDR_WIDTH = 16;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // depth is a power of two, so masking gives the modulo-DEPTH wrap
   function automatic int unsigned wrap_index(input logic [31:0] addr,
                                              input int unsigned lane,
                                              input int unsigned depth);
      return (addr + lane) & (depth - 1);
   endfunction

endpackage

// File: rtl/tc_program_window_if.sv
// rtl/tc_program_window_if.sv - fetch/load bus between fetch logic (master) and program window (slave)
interface tc_program_window_if
   import tc_program_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int NUM_OUT    = DEF_NUM_OUT
);
   logic                          rd_req;
   logic [ADDR_WIDTH-1:0]         rd_addr;
   logic                          rd_ready;
   logic                          rd_valid;
   logic [NUM_OUT*WORD_WIDTH-1:0] out_words;
   logic                          wr_en;
   logic [ADDR_WIDTH-1:0]         wr_addr;
   logic [WORD_WIDTH-1:0]         wr_data;
   logic                          busy;

   modport master (
      output rd_req, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_ready, rd_valid, out_words, busy
   );

   modport slave (
      input  rd_req, rd_addr, wr_en, wr_addr, wr_data,
      output rd_ready, rd_valid, out_words, busy
   );
endinterface

// File: rtl/tc_program_window_mem.sv
// rtl/tc_program_window_mem.sv - DEPTH x WORD_WIDTH program array, one write port, NUM_OUT wrapped read ports
module tc_program_window_mem
   import tc_program_pkg::*;
#(
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int NUM_OUT    = DEF_NUM_OUT,
   parameter int IDX_W      = $clog2(DEPTH)
)(
   input  logic                          clk_i,
   input  logic                          we_i,
   input  logic [IDX_W-1:0]              waddr_i,
   input  logic [WORD_WIDTH-1:0]         wdata_i,
   input  logic [IDX_W-1:0]              raddr_i,
   output logic [NUM_OUT*WORD_WIDTH-1:0] rdata_o
);
   logic [WORD_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
      assign rdata_o[i*WORD_WIDTH +: WORD_WIDTH] =
         mem_q[IDX_W'(wrap_index(32'(raddr_i), i, DEPTH))];
   end
endmodule

// File: rtl/tc_program_window.sv
// rtl/tc_program_window.sv - program memory with registered NUM_OUT-word fetch window
// Optional post-reset clear sweep: TC_PROGRAM_WINDOW_CLEAR_EN
module tc_program_window
   import tc_program_pkg::*;
#(
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int NUM_OUT    = DEF_NUM_OUT,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
)(
   input logic                clk,
   input logic                rst,
   tc_program_window_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int OUT_W = NUM_OUT * WORD_WIDTH;

   logic             ready;
   logic             clearing;
   logic [IDX_W-1:0] clr_idx;

`ifdef TC_PROGRAM_WINDOW_CLEAR_EN
   state_e           state_q, state_d;
   logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
               state_d = ST_READY;
            end
         end
         default: ;
      endcase
   end

   assign ready    = (state_q == ST_READY);
   assign clearing = (state_q == ST_CLEAR);
   assign clr_idx  = clr_cnt_q;
`else
   logic ready_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
      end
   end

   assign ready    = ready_q;
   assign clearing = 1'b0;
   assign clr_idx  = '0;
`endif

   logic                  rd_accept, wr_accept;
   logic                  mem_we;
   logic [IDX_W-1:0]      mem_waddr;
   logic [WORD_WIDTH-1:0] mem_wdata;
   logic [OUT_W-1:0]      mem_rdata;
   logic                  rd_valid_q, rd_valid_d;
   logic [OUT_W-1:0]      out_words_q, out_words_d;

   assign rd_accept = bus.rd_req & ready;
   assign wr_accept = bus.wr_en & ready;
   assign mem_we    = clearing | wr_accept;
   assign mem_waddr = clearing ? clr_idx : bus.wr_addr[IDX_W-1:0];
   assign mem_wdata = clearing ? '0 : bus.wr_data;

   // combinational read sampled at the same edge as the write gives read-before-write
   tc_program_window_mem #(
      .WORD_WIDTH (WORD_WIDTH),
      .DEPTH      (DEPTH),
      .NUM_OUT    (NUM_OUT),
      .IDX_W      (IDX_W)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .raddr_i (bus.rd_addr[IDX_W-1:0]),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      rd_valid_d  = rd_accept;
      out_words_d = rd_accept ? mem_rdata : out_words_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid_q  <= 1'b0;
         out_words_q <= '0;
      end else begin
         rd_valid_q  <= rd_valid_d;
         out_words_q <= out_words_d;
      end
   end

   assign bus.rd_valid  = rd_valid_q;
   assign bus.out_words = out_words_q;
   assign bus.rd_ready  = ready;
   assign bus.busy      = clearing;

   // upper address bits are deliberately ignored (addresses wrap modulo DEPTH)
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.rd_addr, bus.wr_addr};
endmodule

// File: doc/tc_program_window.md
# tc_program_window

Parametrised program memory with a registered multi-word fetch window, the next generation of the fixed 16-bit, four-output program word block. It stores DEPTH words of WORD_WIDTH bits, accepts program loads through a write port, and returns NUM_OUT consecutive words starting at a requested address, one cycle after the request, with a valid strobe. It sits between the program counter / fetch logic and the decoder of a TC-generated CPU.

## Interface
- WORD_WIDTH, 16: bits per program word.
- DEPTH, 256: number of words; must be a power of two, at least 2.
- NUM_OUT, 4: words returned per fetch; must satisfy 1 <= NUM_OUT <= DEPTH.
- ADDR_WIDTH, 16: width of the address ports; must be at least log2(DEPTH).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- rd_req  in  1  fetch request; accepted when rd_req && rd_ready.
- rd_addr  in  ADDR_WIDTH  start address of the fetch window.
- rd_ready  out  1  block can accept a fetch or a write this cycle.
- rd_valid  out  1  one-cycle strobe; out_words updated this cycle.
- out_words  out  NUM_OUT*WORD_WIDTH  lane i = bits [i*WORD_WIDTH +: WORD_WIDTH].
- wr_en  in  1  program-load write; accepted when wr_en && rd_ready.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  WORD_WIDTH  write data.
- busy  out  1  post-reset clear sweep in progress.

## Operation
- Index rule: physical index = address[log2(DEPTH)-1:0]. Upper address bits are ignored, so addresses wrap modulo DEPTH.
- Lane i of an accepted fetch = mem[(rd_addr + i) mod DEPTH]. A window that crosses the top of memory wraps to index 0.
- State machine has two states:
  - CLEAR: writes zero to one entry per cycle, index 0..DEPTH-1. busy=1, rd_ready=0.
  - READY: entered after the last index is cleared. busy=0, rd_ready=1.
- Requests while rd_ready=0 are dropped, with no response. Writes while rd_ready=0 are dropped.
- Accepted write updates mem[wr_addr] at the clock edge.
- Same-cycle read and write to an address inside the window: the read returns the old data (read-before-write).
- out_words holds its value until the next accepted fetch. rd_valid pulses once per accepted fetch.
- Back-to-back fetches are supported at one per cycle.
- Reset values:
  - rd_valid=0, out_words=0, rd_ready=0.
  - busy=1 and the clear counter at 0 when clearing is compiled in; busy=0 otherwise.
- Reset asserted mid-sweep or mid-fetch: all registers return to their reset values and the sweep restarts from index 0 after release. Memory contents are not reset asynchronously.

## Timing
- Fetch latency: 1 cycle. A request accepted at edge N gives rd_valid=1 and new out_words after edge N, for cycle N+1 only.
- Write to fetch: a word written at edge N is visible to a fetch accepted at edge N+1.
- Clear sweep: the first edge after rst deasserts clears index 0. rd_ready rises after edge DEPTH, i.e. DEPTH cycles after release.
- Without the clear sweep, rd_ready=1 from the first cycle after release.

## Configuration
- TC_PROGRAM_WINDOW_CLEAR_EN defined: CLEAR state, clear counter and busy logic are present, and memory reads zero after the sweep.
- TC_PROGRAM_WINDOW_CLEAR_EN undefined: no CLEAR state. The block is in READY after reset, busy is tied to 0, and memory contents after reset are undefined (X in simulation).

## Structure
- Shared package tc_program_pkg holds:
  - the state enum (CLEAR, READY);
  - the default-parameter constants;
  - a function returning the wrapped index for a given address and lane offset.
- One sub-module, tc_program_window_mem: the DEPTH x WORD_WIDTH array with one write port and NUM_OUT combinational read ports. The top level holds the FSM, the clear counter and the output registers.

## Test plan
All scenarios use WORD_WIDTH=16, DEPTH=16, NUM_OUT=4, CLEAR_EN defined.
- Reset release: busy=1 for 16 cycles, then busy=0 and rd_ready=1. Fetch at 0 -> all lanes 0x0000, rd_valid for exactly one cycle.
- Load mem[i]=0x1000+i for i=0..15, then fetch 0x0005 -> lanes 0x1005, 0x1006, 0x1007, 0x1008, returned one cycle later.
- Fetch 0x000E -> lanes 0x100E, 0x100F, 0x1000, 0x1001 (wrap). Fetch 0x0013 -> same result as 0x0003 (upper bits ignored).
- Same cycle: write 0xBEEF to index 6 and fetch 0x0005 -> lane1 is 0x1006. Next fetch 0x0005 -> lane1 is 0xBEEF.
- Fetch and write issued at cycle 3 of the sweep -> no rd_valid, and memory is unchanged after the sweep.
- rst pulsed low mid-sweep and mid-fetch -> outputs return to reset values immediately, and the sweep restarts with 16 busy cycles.
